if_stage: RTL and testbench

Instruction-fetch control stage. It owns the program counter, drives the address into the combinational `fetch` block, and latches the returned instruction into the IF/ID pipeline register consumed by decode. It handles pipeline stall, branch/jump redirect from execute, and halt on `ebreak`.

---
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, IF/ID register, redirect, stall and ebreak halt
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] ir_in,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc_plus4,
  output logic        misalign,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect always returns to RUN so a wrong-path ebreak never sticks.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = RUN;
    end else if (!stall && state_q == RUN && ir_in == EBREAK) begin
      state_d = HALT;
    end
  end

  always_comb begin
    halted      = (state_q == HALT);
    id_pc_plus4 = id_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_ir       <= NOP;
      misalign    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      id_valid <= 1'b0;
      id_ir    <= NOP;
      misalign <= |redirect_pc[1:0];
    end else begin
      misalign <= 1'b0;
      if (!stall) begin
        if (state_q == RUN) begin
          id_pc       <= pc;
          id_ir       <= ir_in;
          id_valid    <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
          if (ir_in != EBREAK) begin
            pc <= pc + 32'd4;
          end
        end else begin
          id_valid <= 1'b0;
          id_ir    <= NOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with directed vectors
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] ir_in = 32'h0080_006f;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_ir;
  logic [31:0] id_pc_plus4;
  logic        misalign;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        v;
    logic [31:0] id_pc;
    logic [31:0] id_ir;
    logic        mis;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  if_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .ir_in(ir_in), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_pc(id_pc), .id_ir(id_ir), .id_pc_plus4(id_pc_plus4),
    .misalign(misalign), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
    end
  endtask

  // Monitor: the IF/ID outputs are updated every edge, so each edge consumes one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc",          e.idx, pc,               e.pc);
        chk("id_valid",    e.idx, {31'd0, id_valid}, {31'd0, e.v});
        chk("id_pc",       e.idx, id_pc,            e.id_pc);
        chk("id_ir",       e.idx, id_ir,            e.id_ir);
        chk("id_pc_plus4", e.idx, id_pc_plus4,      e.id_pc + 32'd4);
        chk("misalign",    e.idx, {31'd0, misalign}, {31'd0, e.mis});
        chk("halted",      e.idx, {31'd0, halted},   {31'd0, e.halt});
        chk("fetch_count", e.idx, fetch_count,      e.cnt);
      end
    end
  end

  int step_no = 0;

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                      input logic [31:0] ir, input logic [31:0] e_pc, input logic e_v,
                      input logic [31:0] e_idpc, input logic [31:0] e_ir, input logic e_mis,
                      input logic e_halt, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; ir_in = ir;
    step_no++;
    e.idx = step_no; e.pc = e_pc; e.v = e_v; e.id_pc = e_idpc; e.id_ir = e_ir;
    e.mis = e_mis; e.halt = e_halt; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  initial begin
    //    rst st rd rpc            ir_in          pc             v  id_pc          id_ir          mis hlt cnt
    step(1, 0, 0, 32'h0,         32'h0080006f, 32'h00002000, 0, 32'h00000000, NOPI,          0, 0, 0);
    step(1, 0, 0, 32'h0,         32'h0080006f, 32'h00002000, 0, 32'h00000000, NOPI,          0, 0, 0);
    step(0, 0, 0, 32'h0,         32'h0080006f, 32'h00002004, 1, 32'h00002000, 32'h0080006f,  0, 0, 1);
    step(0, 1, 0, 32'h0,         32'h11111111, 32'h00002004, 1, 32'h00002000, 32'h0080006f,  0, 0, 1);
    step(0, 1, 0, 32'h0,         32'h11111111, 32'h00002004, 1, 32'h00002000, 32'h0080006f,  0, 0, 1);
    step(0, 1, 0, 32'h0,         32'h11111111, 32'h00002004, 1, 32'h00002000, 32'h0080006f,  0, 0, 1);
    step(0, 0, 0, 32'h0,         32'h00000093, 32'h00002008, 1, 32'h00002004, 32'h00000093,  0, 0, 2);
    // ebreak at 0x2008 halts, then the halted stage drains to a bubble
    step(0, 0, 0, 32'h0,         EBRK,         32'h00002008, 1, 32'h00002008, EBRK,          0, 1, 3);
    step(0, 0, 0, 32'h0,         EBRK,         32'h00002008, 0, 32'h00002008, NOPI,          0, 1, 3);
    step(0, 1, 0, 32'h0,         EBRK,         32'h00002008, 0, 32'h00002008, NOPI,          0, 1, 3);
    step(0, 0, 1, 32'h00003000,  EBRK,         32'h00003000, 0, 32'h00002008, NOPI,          0, 0, 3);
    step(0, 0, 0, 32'h0,         32'h00000113, 32'h00003004, 1, 32'h00003000, 32'h00000113,  0, 0, 4);
    // redirect wins over simultaneous stall
    step(0, 1, 1, 32'h00002010,  32'h11111111, 32'h00002010, 0, 32'h00003000, NOPI,          0, 0, 4);
    step(0, 0, 0, 32'h0,         32'h00000193, 32'h00002014, 1, 32'h00002010, 32'h00000193,  0, 0, 5);
    step(0, 0, 1, 32'h00002013,  32'h11111111, 32'h00002010, 0, 32'h00002010, NOPI,          1, 0, 5);
    step(0, 0, 0, 32'h0,         32'h00000213, 32'h00002014, 1, 32'h00002010, 32'h00000213,  0, 0, 6);
    step(0, 0, 0, 32'h0,         EBRK,         32'h00002014, 1, 32'h00002014, EBRK,          0, 1, 7);
    // redirect out of HALT to the top of the address space, then wrap
    step(0, 0, 1, 32'hFFFFFFFC,  EBRK,         32'hFFFFFFFC, 0, 32'h00002014, NOPI,          0, 0, 7);
    step(0, 0, 0, 32'h0,         32'h00000293, 32'h00000000, 1, 32'hFFFFFFFC, 32'h00000293,  0, 0, 8);
    // reset during stall, and reset beating a redirect
    step(1, 1, 0, 32'h0,         32'h00000293, 32'h00002000, 0, 32'h00000000, NOPI,          0, 0, 0);
    step(1, 0, 1, 32'h00005001,  32'h00000293, 32'h00002000, 0, 32'h00000000, NOPI,          0, 0, 0);
    step(0, 0, 0, 32'h0,         EBRK,         32'h00002000, 1, 32'h00002000, EBRK,          0, 1, 1);
    step(1, 0, 0, 32'h0,         EBRK,         32'h00002000, 0, 32'h00000000, NOPI,          0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
